// File: rtl/vga_pkg.sv
// Shared constants and types for the BBC-to-VGA scan doubler.
// Latency: n/a. Backpressure: n/a.
package vga_pkg;
    localparam int PIXELS = 640;
    localparam int LINES  = 480;
    localparam int BPP    = 3;
    localparam int AW     = 10;

    typedef logic [BPP-1:0] rgb_t;
    typedef logic [AW-1:0]  lb_addr_t;
endpackage

// File: rtl/vga_line_doubler_if.sv
// Source-side strobes, VGA timing inputs and doubled RGB output of the scan doubler.
// Latency: n/a (wires only). Backpressure: none; every signal is a free-running timing strobe.
interface vga_line_doubler_if #(parameter int BPP = vga_pkg::BPP);
    logic           SRC_PIXEL_EN;
    logic [BPP-1:0] SRC_RGB;
    logic           SRC_DISEN;
    logic           SRC_NEWLINE;
    logic           SRC_NEWSCREEN;
    logic           NEWLINE;
    logic           NEWSCREEN;
    logic           DISEN;
    logic [BPP-1:0] VGA_RGB;
    logic           LINE_VALID;
    logic           COLLIDE;

    modport master (
        output SRC_PIXEL_EN, SRC_RGB, SRC_DISEN, SRC_NEWLINE, SRC_NEWSCREEN,
        output NEWLINE, NEWSCREEN, DISEN,
        input  VGA_RGB, LINE_VALID, COLLIDE
    );

    modport slave (
        input  SRC_PIXEL_EN, SRC_RGB, SRC_DISEN, SRC_NEWLINE, SRC_NEWSCREEN,
        input  NEWLINE, NEWSCREEN, DISEN,
        output VGA_RGB, LINE_VALID, COLLIDE
    );
endinterface

// File: rtl/vga_line_doubler_ram.sv
// Two-bank line buffer, simple dual port, addressed as {bank, ptr}.
// Latency: 1 cycle registered read, read-first on same-address collision. Backpressure: none.
module line_buffer_ram #(
    parameter int PIXELS = vga_pkg::PIXELS,
    parameter int AW     = vga_pkg::AW,
    parameter int BPP    = vga_pkg::BPP
) (
    input  logic           PIXELCLK,
    input  logic           we,
    input  logic [AW:0]    waddr,
    input  logic [BPP-1:0] wdata,
    input  logic [AW:0]    raddr,
    output logic [BPP-1:0] rdata
);
    logic [BPP-1:0] mem [2][PIXELS];

    // Both ports in one block with non-blocking writes gives read-first behaviour.
    always_ff @(posedge PIXELCLK) begin
        if (we) begin
            mem[waddr[AW]][waddr[AW-1:0]] <= wdata;
        end
        rdata <= mem[raddr[AW]][raddr[AW-1:0]];
    end
endmodule

// File: rtl/vga_line_doubler.sv
// Scan doubler: captures each 15.6 kHz source line into a ping-pong buffer and replays it twice on VGA timing.
// Latency: VGA_RGB is registered one cycle after the registered RAM read (DISEN sampled -> pixel two edges later).
// Backpressure: none; overlong source lines drop pixels, and writer/reader bank clashes are only flagged on COLLIDE.
module vga_line_doubler #(
    parameter int PIXELS = vga_pkg::PIXELS,
    parameter int AW     = vga_pkg::AW,
    parameter int BPP    = vga_pkg::BPP
) (
    input logic               PIXELCLK,
    input logic               nRESET,
    vga_line_doubler_if.slave vga
);
    import vga_pkg::*;

    localparam logic [AW:0]   WR_LIMIT = (AW+1)'(PIXELS);
    localparam logic [AW-1:0] RD_LAST  = AW'(PIXELS - 1);

    logic           wr_bank, rd_bank, rep, src_frame;
    logic [AW:0]    wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           disen_d, line_valid, collide;
    logic [BPP-1:0] ram_q, vga_rgb;
    logic           wr_en;

    assign wr_en = vga.SRC_PIXEL_EN & vga.SRC_DISEN & (wr_ptr < WR_LIMIT);

    line_buffer_ram #(.PIXELS(PIXELS), .AW(AW), .BPP(BPP)) u_ram (
        .PIXELCLK (PIXELCLK),
        .we       (wr_en),
        .waddr    ({wr_bank, wr_ptr[AW-1:0]}),
        .wdata    (vga.SRC_RGB),
        .raddr    ({rd_bank, rd_ptr}),
        .rdata    (ram_q)
    );

    always_ff @(posedge PIXELCLK) begin
        if (!nRESET) begin
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rep        <= 1'b0;
            src_frame  <= 1'b0;
            disen_d    <= 1'b0;
            line_valid <= 1'b0;
            collide    <= 1'b0;
            vga_rgb    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (vga.SRC_NEWLINE) begin
                wr_bank    <= ~wr_bank;
                wr_ptr     <= '0;
                line_valid <= 1'b1;
            end
            if (vga.SRC_NEWSCREEN) begin
                src_frame <= ~src_frame;
            end

            if (vga.DISEN && (rd_ptr != RD_LAST)) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Bank selection samples wr_bank before any same-cycle SRC_NEWLINE toggle,
            // so a coincident source line end leaves the reader one line behind.
            if (vga.NEWSCREEN) begin
                rep <= 1'b0;
                if (vga.NEWLINE) begin
                    rd_ptr  <= '0;
                    rd_bank <= ~wr_bank;
                end
            end else if (vga.NEWLINE) begin
                rd_ptr <= '0;
                rep    <= ~rep;
                if (!rep) begin
                    rd_bank <= ~wr_bank;
                end
            end

            collide <= vga.SRC_NEWLINE & vga.DISEN & ((~wr_bank) == rd_bank);
            disen_d <= vga.DISEN;
            vga_rgb <= (disen_d & line_valid) ? ram_q : '0;
        end
    end

    assign vga.VGA_RGB    = vga_rgb;
    assign vga.LINE_VALID = line_valid;
    assign vga.COLLIDE    = collide;
endmodule
